// File: rtl/dmem_unit.sv
// MEM-stage data memory unit: byte/half/word loads and stores on a word RAM,
// with valid/ready request acceptance, programmable latency and a done pulse.
module dmem_unit #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        memwrite,
  input  logic        memread,
  input  logic [1:0]  swhb,
  input  logic [1:0]  lwhb,
  input  logic        lunsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned BW = AW + 2;
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic {IDLE, WAIT} state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic            wr_q;
  logic [1:0]      size_q;
  logic            uns_q;
  logic [BW-1:0]   addr_q;
  logic [31:0]     wdata_q;

  logic [31:0]     mem [DEPTH];

  logic            illegal_c;
  logic            active_c;
  logic            fire_c;
  logic            we_c;
  logic [3:0]      be_c;
  logic [31:0]     wlane_c;
  logic [31:0]     word_c;
  logic [31:0]     load_c;
  logic [15:0]     half_c;
  logic [7:0]      byte_c;
  logic            unused_addr_bits;

  // Address bits above the RAM window wrap and are intentionally dropped.
  assign unused_addr_bits = ^addr[31:BW];

  assign req_ready = (state_q == IDLE);
  assign active_c  = memwrite | memread;
  assign fire_c    = (state_q == WAIT) && (cnt_q == '0);
  assign we_c      = fire_c && wr_q;
  assign word_c    = mem[addr_q[BW-1:2]];

  // Request legality: conflicting kinds, reserved size codes, misalignment.
  always_comb begin
    illegal_c = memwrite & memread;
    if (memwrite) begin
      case (swhb)
        2'b00:   illegal_c = 1'b1;
        2'b01:   if (addr[1:0] != 2'b00) illegal_c = 1'b1;
        2'b10:   if (addr[0]) illegal_c = 1'b1;
        default: ;
      endcase
    end
    if (memread) begin
      case (lwhb)
        2'b11:   illegal_c = 1'b1;
        2'b01:   if (addr[0]) illegal_c = 1'b1;
        default: ;
      endcase
    end
  end

  // Store lane enables and lane-replicated write data (store size encoding).
  always_comb begin
    be_c    = 4'b0000;
    wlane_c = wdata_q;
    case (size_q)
      2'b01: be_c = 4'b1111;
      2'b10: begin
        be_c    = addr_q[1] ? 4'b1100 : 4'b0011;
        wlane_c = {2{wdata_q[15:0]}};
      end
      2'b11: begin
        be_c    = 4'b0001 << addr_q[1:0];
        wlane_c = {4{wdata_q[7:0]}};
      end
      default: ;
    endcase
  end

  // Load lane selection and extension (load size encoding).
  always_comb begin
    half_c = addr_q[1] ? word_c[31:16] : word_c[15:0];
    case (addr_q[1:0])
      2'b00:   byte_c = word_c[7:0];
      2'b01:   byte_c = word_c[15:8];
      2'b10:   byte_c = word_c[23:16];
      default: byte_c = word_c[31:24];
    endcase
    case (size_q)
      2'b01:   load_c = uns_q ? {16'h0000, half_c} : {{16{half_c[15]}}, half_c};
      2'b10:   load_c = uns_q ? {24'h000000, byte_c} : {{24{byte_c[7]}}, byte_c};
      default: load_c = word_c;
    endcase
  end

  always_ff @(posedge clk) begin
    if (we_c) begin
      for (int k = 0; k < 4; k++) begin
        if (be_c[k]) mem[addr_q[BW-1:2]][8*k +: 8] <= wlane_c[8*k +: 8];
      end
    end
  end

  // Control FSM with registered completion outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid && active_c) begin
            if (illegal_c) begin
              done  <= 1'b1;
              err   <= 1'b1;
              rdata <= '0;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CW'(LATENCY - 1);
              wr_q    <= memwrite;
              size_q  <= memwrite ? swhb : lwhb;
              uns_q   <= lunsigned;
              addr_q  <= addr[BW-1:0];
              wdata_q <= wdata;
            end
          end
        end
        WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            state_q <= IDLE;
            done    <= 1'b1;
            rdata   <= wr_q ? 32'h0 : load_c;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_unit.sv
// Randomized bench for dmem_unit against a byte-addressed reference memory.
module tb_dmem_unit;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT   = 3;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        memwrite;
  logic        memread;
  logic [1:0]  swhb;
  logic [1:0]  lwhb;
  logic        lunsigned;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        done;
  logic        err;
  logic [31:0] rdata;

  dmem_unit #(.DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .memwrite  (memwrite),
    .memread   (memread),
    .swhb      (swhb),
    .lwhb      (lwhb),
    .lunsigned (lunsigned),
    .addr      (addr),
    .wdata     (wdata),
    .done      (done),
    .err       (err),
    .rdata     (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  mb [4*DEPTH];
  logic [31:0] last_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: byte array, access width from size code, alignment rules.
  task automatic model(input bit mw, input bit mr, input bit [1:0] ssz, input bit [1:0] lsz,
                       input bit uns, input bit [31:0] a, input bit [31:0] wd,
                       output bit act, output bit ill, output bit [31:0] rd);
    int n;
    int base;
    bit [31:0] v;
    act = mw || mr;
    ill = 1'b0;
    rd  = 32'h0;
    if (!act) return;
    if (mw && mr) begin ill = 1'b1; return; end
    if (mw) n = (ssz == 2'd1) ? 4 : (ssz == 2'd2) ? 2 : (ssz == 2'd3) ? 1 : 0;
    else    n = (lsz == 2'd0) ? 4 : (lsz == 2'd1) ? 2 : (lsz == 2'd2) ? 1 : 0;
    if (n == 0) begin ill = 1'b1; return; end
    if (!(mr && n == 4) && (a % n) != 0) begin ill = 1'b1; return; end
    base = int'(a % (4 * DEPTH)) / n * n;
    if (mw) begin
      for (int i = 0; i < n; i++) mb[base + i] = wd[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = mb[base + i];
      if (n < 4 && !uns && v[8*n-1]) begin
        for (int b = 8 * n; b < 32; b++) v[b] = 1'b1;
      end
      rd = v;
    end
  endtask

  task automatic access(input bit mw, input bit mr, input bit [1:0] ssz, input bit [1:0] lsz,
                        input bit uns, input bit [31:0] a, input bit [31:0] wd, input bit hold);
    bit act;
    bit ill;
    bit [31:0] rd;
    bit seen;
    int n;
    int guard;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("ready_before_req", 32'(req_ready), 32'd1);
    model(mw, mr, ssz, lsz, uns, a, wd, act, ill, rd);
    memwrite  = mw;
    memread   = mr;
    swhb      = ssz;
    lwhb      = lsz;
    lunsigned = uns;
    addr      = a;
    wdata     = wd;
    req_valid = 1'b1;
    @(negedge clk);
    if (!act) begin
      req_valid = 1'b0;
      seen = done;
      repeat (LAT + 1) begin
        @(negedge clk);
        seen |= done;
      end
      check("noop_no_done", 32'(seen), 32'd0);
      check("noop_ready", 32'(req_ready), 32'd1);
      return;
    end
    n = 1;
    while (done !== 1'b1 && n < int'(LAT) + 4) begin
      check("wait_ready_low", 32'(req_ready), 32'd0);
      if (hold) begin
        memwrite = 1'b1;
        memread  = 1'b0;
        swhb     = 2'd1;
        addr     = {$urandom_range(0, 255), 2'b00};
        wdata    = $urandom;
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    req_valid = 1'b0;
    check("done_seen", 32'(done), 32'd1);
    check("latency", 32'(n), ill ? 32'd1 : 32'(LAT + 1));
    check("err", 32'(err), 32'(ill));
    check("rdata", rdata, rd);
    check("ready_at_done", 32'(req_ready), 32'd1);
    last_rd = rdata;
  endtask

  task automatic st(input bit [1:0] sz, input bit [31:0] a, input bit [31:0] d);
    access(1'b1, 1'b0, sz, 2'd0, 1'b0, a, d, 1'b0);
  endtask

  task automatic ld(input bit [1:0] sz, input bit uns, input bit [31:0] a, input bit hold);
    access(1'b0, 1'b1, 2'd1, sz, uns, a, 32'h0, hold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    bit [31:0] r;
    int k;
    bit mw, mr, uns, hold;
    bit [1:0] ssz, lsz;

    reset = 1'b0; req_valid = 1'b0; memwrite = 1'b0; memread = 1'b0;
    swhb = 2'd0; lwhb = 2'd0; lunsigned = 1'b0; addr = '0; wdata = '0;
    last_rd = '0;
    #12;
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);

    for (int w = 0; w < 64; w++) st(2'd1, 32'(w * 4), $urandom);

    st(2'd1, 32'h10, 32'hDEADBEEF);
    ld(2'd0, 1'b0, 32'h10, 1'b1);
    check("lw_beef", last_rd, 32'hDEADBEEF);
    st(2'd3, 32'h11, 32'h000000AA);
    ld(2'd0, 1'b0, 32'h10, 1'b0);
    check("lw_after_sb", last_rd, 32'hDEADAAEF);
    ld(2'd2, 1'b0, 32'h11, 1'b0);
    check("lb", last_rd, 32'hFFFFFFAA);
    ld(2'd2, 1'b1, 32'h11, 1'b0);
    check("lbu", last_rd, 32'h000000AA);
    ld(2'd1, 1'b0, 32'h12, 1'b0);
    check("lh", last_rd, 32'hFFFFDEAD);
    ld(2'd1, 1'b1, 32'h12, 1'b0);
    check("lhu", last_rd, 32'h0000DEAD);

    st(2'd1, 32'h13, 32'h55555555);
    ld(2'd1, 1'b0, 32'h11, 1'b0);
    access(1'b1, 1'b1, 2'd1, 2'd0, 1'b0, 32'h10, 32'h66666666, 1'b0);
    st(2'd0, 32'h10, 32'h77777777);
    ld(2'd3, 1'b0, 32'h10, 1'b0);
    st(2'd2, 32'h11, 32'h00008888);
    ld(2'd0, 1'b0, 32'h10, 1'b0);
    check("lw_after_illegal", last_rd, 32'hDEADAAEF);

    st(2'd1, 32'h1000, 32'h12345678);
    ld(2'd0, 1'b0, 32'h0, 1'b0);
    check("wrap", last_rd, 32'h12345678);

    st(2'd1, 32'h20, 32'h0);
    ld(2'd0, 1'b0, 32'h10, 1'b0);
    memwrite = 1'b1; memread = 1'b0; swhb = 2'd1; addr = 32'h20; wdata = 32'h11111111;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    memwrite = 1'b0;
    @(posedge clk);
    #1;
    check("abort_wait_ready", 32'(req_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("abort_done", 32'(done), 32'd0);
    check("abort_rdata", rdata, 32'd0);
    check("abort_ready", 32'(req_ready), 32'd1);
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      seen |= done;
    end
    reset = 1'b1;
    repeat (LAT + 1) begin
      @(negedge clk);
      seen |= done;
    end
    check("abort_no_done", 32'(seen), 32'd0);
    ld(2'd0, 1'b0, 32'h20, 1'b0);
    check("abort_no_write", last_rd, 32'h0);

    for (int it = 0; it < 300; it++) begin
      k = $urandom_range(0, 15);
      mw = (k < 6) || (k == 13);
      mr = (k >= 6 && k < 12) || (k >= 13);
      ssz  = 2'($urandom);
      lsz  = 2'($urandom);
      uns  = 1'($urandom);
      hold = 1'($urandom);
      r = $urandom;
      access(mw, mr, ssz, lsz, uns, {r[31:12], 4'b0000, r[7:0]}, $urandom, hold);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
